// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, complex packing helpers and the
// index bit-reversal used by the stage wrappers and the output serializer.
`ifndef FFT_PKG_SV
`define FFT_PKG_SV

// Sample j of a flat bus that carries one DATA_W-bit component per sample.
`define FFT_CPLX_GET(bus, j) bus[fft_pkg::DATA_W*(j) +: fft_pkg::DATA_W]

package fft_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_LOGN = 6;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } ser_state_e;

  // Reverses the low logn bits of k; bits at and above logn come back zero.
  function automatic logic [MAX_LOGN-1:0] bitrev(input logic [MAX_LOGN-1:0] k,
                                                 input int logn);
    logic [MAX_LOGN-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_LOGN; b++) begin
      if (b < logn) r[logn-1-b] = k[b];
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/fft_round_shift.sv
// Combinational round-half-up arithmetic right shift of one signed sample.
module fft_round_shift
  import fft_pkg::*;
#(
  parameter int SCALE_SHIFT = 0
) (
  input  sample_t x,
  output sample_t y
);

  generate
    if (SCALE_SHIFT == 0) begin : g_pass
      assign y = x;
    end else begin : g_round
      localparam int HALF = 1 << (SCALE_SHIFT - 1);
      // One extra bit of headroom so the rounding add of a positive full-scale
      // value cannot wrap before the shift brings it back into range.
      logic signed [DATA_W:0] sum;
      assign sum = $signed({x[DATA_W-1], x}) + $signed((DATA_W+1)'(HALF));
      assign y   = DATA_W'(sum >>> SCALE_SHIFT);
    end
  endgenerate

endmodule

// File: rtl/fft_out_serializer.sv
// Captures a full parallel FFT frame in one cycle and streams it out one
// complex sample per beat, optionally bit-reversed and rounded-scaled.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int N           = 8,
  parameter int LOGN        = $clog2(N),
  parameter int BITREV      = 1,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*N-1:0]      in_r,
  input  logic [DATA_W*N-1:0]      in_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic [LOGN-1:0]          out_idx,
  output logic                     out_last
);

  ser_state_e      state_q, state_d;
  logic [LOGN-1:0] count;
  logic [LOGN-1:0] sel_idx;
  logic            at_last;
  logic            load;
  logic            advance;
  cplx_t           buffer [N];
  sample_t         scaled_r, scaled_i;

  assign at_last = (count == LOGN'(N - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          advance = 1'b1;
          if (at_last) begin
            // Final beat leaves: the next frame may land in the same edge.
            in_ready = 1'b1;
            if (in_valid) load    = 1'b1;
            else          state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (load)         count <= '0;
      else if (advance) count <= count + LOGN'(1);
    end
  end

  // NOTE: the frame buffer is deliberately left out of reset; its contents
  // are only observed after a load, and a reset net here would cost a lot.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < N; j++) begin
        buffer[j] <= '{re: `FFT_CPLX_GET(in_r, j), im: `FFT_CPLX_GET(in_i, j)};
      end
    end
  end

  generate
    if (BITREV != 0) begin : g_bitrev
      assign sel_idx = LOGN'(bitrev(MAX_LOGN'(count), LOGN));
    end else begin : g_natural
      assign sel_idx = count;
    end
  endgenerate

  fft_round_shift #(.SCALE_SHIFT(SCALE_SHIFT)) u_shift_r (
    .x (buffer[sel_idx].re),
    .y (scaled_r)
  );

  fft_round_shift #(.SCALE_SHIFT(SCALE_SHIFT)) u_shift_i (
    .x (buffer[sel_idx].im),
    .y (scaled_i)
  );

  // Outputs read zero whenever no sample is presented, so the unreset buffer
  // never shows through while idle.
  assign out_valid = (state_q == ST_STREAM);
  assign out_last  = out_valid && at_last;
  assign out_idx   = out_valid ? count : '0;
  assign out_r     = out_valid ? scaled_r : '0;
  assign out_i     = out_valid ? scaled_i : '0;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Drives four serializer configurations with one stimulus stream and checks
// each against a frame-level queue model plus directed corner sequences.
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int NG = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [16*N-1:0]     in_r = '0;
  logic [16*N-1:0]     in_i = '0;
  logic                in_ready  [NG];
  logic                out_valid [NG];
  logic                out_last  [NG];
  logic signed [15:0]  out_r     [NG];
  logic signed [15:0]  out_i     [NG];
  logic [2:0]          out_idx   [NG];

  // Config g: BITREV = g%2; SCALE_SHIFT = 0,0,1,3.
  for (genvar g = 0; g < NG; g++) begin : g_dut
    fft_out_serializer #(
      .N           (N),
      .BITREV      (g % 2),
      .SCALE_SHIFT ((g == 2) ? 1 : ((g == 3) ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_r      (in_r),
      .in_i      (in_i),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_r     (out_r[g]),
      .out_i     (out_i[g]),
      .out_idx   (out_idx[g]),
      .out_last  (out_last[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int r;
    int i;
    int idx;
    bit last;
  } beat_t;

  beat_t q [NG][$];
  bit    acc;

  function automatic int br_of(int g);
    return g % 2;
  endfunction

  function automatic int ss_of(int g);
    return (g == 2) ? 1 : ((g == 3) ? 3 : 0);
  endfunction

  function automatic int brev3(int k);
    int r = 0;
    for (int b = 0; b < 3; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic int scale(int x, int s);
    if (s == 0) return x;
    return (x + (1 << (s - 1))) >>> s;
  endfunction

  always @(negedge clk) begin
    bit    ev, eir;
    beat_t b;
    int    s;
    acc = in_valid && in_ready[0] && rst_n;
    for (int g = 0; g < NG; g++) begin
      if (!rst_n) begin
        q[g].delete();
        check($sformatf("mon%0d out_valid in reset", g), int'(out_valid[g]), 0);
      end else begin
        ev  = (q[g].size() != 0);
        eir = !ev || (q[g].size() == 1 && out_ready);
        check($sformatf("mon%0d out_valid", g), int'(out_valid[g]), int'(ev));
        check($sformatf("mon%0d in_ready", g), int'(in_ready[g]), int'(eir));
        if (ev) begin
          check($sformatf("mon%0d out_r", g), int'(out_r[g]), q[g][0].r);
          check($sformatf("mon%0d out_i", g), int'(out_i[g]), q[g][0].i);
          check($sformatf("mon%0d out_idx", g), int'(out_idx[g]), q[g][0].idx);
          check($sformatf("mon%0d out_last", g), int'(out_last[g]), int'(q[g][0].last));
          if (out_ready) void'(q[g].pop_front());
        end
        if (in_valid && eir) begin
          for (int k = 0; k < N; k++) begin
            s      = br_of(g) ? brev3(k) : k;
            b.r    = scale(int'($signed(in_r[16*s +: 16])), ss_of(g));
            b.i    = scale(int'($signed(in_i[16*s +: 16])), ss_of(g));
            b.idx  = k;
            b.last = (k == N - 1);
            q[g].push_back(b);
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int r[N], input int im[N]);
    for (int j = 0; j < N; j++) begin
      in_r[16*j +: 16] = 16'(r[j]);
      in_i[16*j +: 16] = 16'(im[j]);
    end
  endtask

  // Presents a frame and returns in the cycle after it was accepted.
  task automatic send(input int r[N], input int im[N]);
    bit done = 1'b0;
    set_frame(r, im);
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      cyc();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    check("send handshake within budget", int'(done), 1);
  endtask

  typedef struct {
    int x;
    int y;
  } sc_vec_t;

  int      fa_r [N];
  int      fa_i [N];
  int      fb_r [N];
  int      fb_i [N];
  int      fr_r [N];
  int      fr_i [N];
  int      exp_br [N];
  sc_vec_t sc_tbl [N];
  bit      stall_pat [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int bt;
    int sent;
    fa_r   = '{32767, 16384, 0, -16384, -32767, -16384, 0, 16384};
    fa_i   = '{0, 16384, 32767, 16384, 0, -16384, -32767, -16384};
    exp_br = '{32767, -32767, 0, 0, 16384, -16384, -16384, 16384};
    for (int j = 0; j < N; j++) begin
      fb_r[j] = 100;
      fb_i[j] = -100;
    end
    sc_tbl = '{'{32767, 16384}, '{-32767, -16383}, '{-16384, -8192}, '{1, 1},
               '{-1, 0}, '{2, 1}, '{-2, -1}, '{3, 2}};
    stall_pat = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    // Reset state
    cyc();
    check("reset out_valid", int'(out_valid[0]), 0);
    check("reset in_ready", int'(in_ready[0]), 1);
    check("reset out_idx", int'(out_idx[0]), 0);
    check("reset out_last", int'(out_last[0]), 0);
    check("reset out_r", int'(out_r[0]), 0);
    check("reset out_i", int'(out_i[0]), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Natural and bit-reversed order, full-rate drain
    out_ready = 1'b1;
    send(fa_r, fa_i);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check($sformatf("nat beat%0d out_r", k), int'(out_r[0]), fa_r[k]);
      check($sformatf("nat beat%0d out_i", k), int'(out_i[0]), fa_i[k]);
      check($sformatf("nat beat%0d out_idx", k), int'(out_idx[0]), k);
      check($sformatf("nat beat%0d out_last", k), int'(out_last[0]), int'(k == N - 1));
      check($sformatf("brev beat%0d out_r", k), int'(out_r[1]), exp_br[k]);
      check($sformatf("brev beat%0d out_idx", k), int'(out_idx[1]), k);
    end
    @(negedge clk);
    check("after frame in_ready", int'(in_ready[0]), 1);
    check("after frame out_valid", int'(out_valid[0]), 0);
    cyc();

    // Backpressure on beats 2 and 5
    send(fa_r, fa_i);
    bt = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = stall_pat[c];
      @(negedge clk);
      check($sformatf("bp cycle%0d out_idx", c), int'(out_idx[0]), bt);
      if (c < 13) check($sformatf("bp cycle%0d in_ready", c), int'(in_ready[0]), 0);
      if (out_ready) bt++;
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp beats delivered", bt, N);
    check("bp drained out_valid", int'(out_valid[0]), 0);
    cyc();

    // Back-to-back frames with no bubble
    send(fa_r, fa_i);
    set_frame(fb_r, fb_i);
    in_valid = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      check($sformatf("b2b cycle%0d out_valid", c), int'(out_valid[0]), 1);
      check($sformatf("b2b cycle%0d out_idx", c), int'(out_idx[0]), c % N);
      if (c == N - 1) check("b2b in_ready on last beat", int'(in_ready[0]), 1);
      if (c >= N) check($sformatf("b2b cycle%0d out_r", c), int'(out_r[0]), 100);
      cyc();
      if (acc) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b drained out_valid", int'(out_valid[0]), 0);
    cyc();

    // Rounded shift by 1 on the natural-order config
    for (int j = 0; j < N; j++) begin
      fr_r[j] = sc_tbl[j].x;
      fr_i[j] = -sc_tbl[j].x;
    end
    send(fr_r, fr_i);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check($sformatf("scale x=%0d", sc_tbl[k].x), int'(out_r[2]), sc_tbl[k].y);
    end
    cyc();

    // Reset asserted during beat 3
    send(fa_r, fa_i);
    cyc();
    cyc();
    cyc();
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NG; g++) begin
      check($sformatf("mid reset dut%0d out_valid", g), int'(out_valid[g]), 0);
      check($sformatf("mid reset dut%0d in_ready", g), int'(in_ready[g]), 1);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", int'(in_ready[0]), 1);
    check("post reset out_valid", int'(out_valid[0]), 0);
    cyc();
    send(fa_r, fa_i);
    @(negedge clk);
    check("post reset first out_idx", int'(out_idx[0]), 0);
    check("post reset first out_r", int'(out_r[0]), fa_r[0]);
    for (int k = 0; k < N; k++) cyc();

    // Randomized frames and backpressure
    sent = 0;
    for (int c = 0; c < 3000 && sent < 30; c++) begin
      cyc();
      out_ready = ($urandom % 4) != 0;
      if (acc && in_valid) begin
        in_valid = 1'b0;
        sent++;
      end
      if (!in_valid && ($urandom % 3) == 0) begin
        for (int j = 0; j < N; j++) begin
          fr_r[j] = int'($urandom_range(65535)) - 32768;
          fr_i[j] = int'($urandom_range(65535)) - 32768;
        end
        set_frame(fr_r, fr_i);
        in_valid = 1'b1;
      end
    end
    for (int c = 0; c < 40; c++) begin
      cyc();
      out_ready = 1'b1;
      if (acc) in_valid = 1'b0;
    end
    check("random frames sent", int'(sent >= 30), 1);
    for (int g = 0; g < NG; g++) begin
      check($sformatf("dut%0d model drained", g), q[g].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Output-side reader for the combinational fft_stage / FFT core.
- Captures one full frame of N parallel complex results (16-bit signed real/imag) in a single cycle.
- Streams the frame out one sample per cycle on a valid/ready interface, in natural or bit-reversed index order.
- Optionally scales each sample by a rounded arithmetic right shift.

Parameters:
- N, 8, FFT size (power of 2, 2..64).
- LOGN, $clog2(N), index width.
- BITREV, 1, 1 = sample k is taken from buffer[bitrev(k)] (natural-order output from a DIT core); 0 = buffer[k].
- SCALE_SHIFT, 0, right-shift amount 0..15 applied to both real and imag.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  frame on in_r/in_i is valid.
- in_ready  output  1  serializer can accept a frame this cycle.
- in_r  input  16*N  real parts, packed; sample j at bits [16j+15:16j].
- in_i  input  16*N  imag parts, same packing.
- out_valid  output  1  out_r/out_i/out_idx hold a valid sample.
- out_ready  input  1  downstream accepts the sample.
- out_r  output  16  real part of current sample, signed.
- out_i  output  16  imag part of current sample, signed.
- out_idx  output  LOGN  output-order index k of current sample.
- out_last  output  1  high with the sample where k = N-1.

Behaviour:
- Reset (async assert, sync release): state = IDLE, count = 0, out_valid = 0, out_last = 0, out_idx = 0, out_r = out_i = 0, buffer contents don't-care.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid: latch all N samples into buffer, count = 0, go to STREAM.
  - STREAM: out_valid = 1. Outputs are combinational from buffer[sel(count)] and count. On out_ready: count += 1.
    - Beat with count = N-1 accepted and in_valid = 1: load the new frame in the same cycle, count = 0, stay in STREAM (back-to-back, no bubble).
    - Beat with count = N-1 accepted and in_valid = 0: go to IDLE.
- in_ready = (state == IDLE) or (state == STREAM and count == N-1 and out_ready). This is a combinational out_ready -> in_ready path and is accepted.
- Latency: frame accepted at edge t; first sample has out_valid = 1 in cycle t+1. Full frame takes N cycles with out_ready held high.
- Backpressure: while out_valid = 1 and out_ready = 0, out_r, out_i, out_idx and out_last stay stable, and count and buffer do not change.
- in_valid while in_ready = 0 is ignored. The upstream holds the frame until in_ready.
- Index selection: sel(k) = bit-reversal of k over LOGN bits when BITREV = 1, else k. out_idx always reports k, not sel(k).
- Scaling: for SCALE_SHIFT = S > 0, y = (x + 2^(S-1)) >>> S, computed in 17-bit signed arithmetic and truncated to 16 bits (cannot overflow). For S = 0, y = x.
- Reset mid-frame: remaining samples are discarded, and the block comes up in IDLE with in_ready = 1 after rst_n deasserts.

Decomposition:
- Shared package/include fft_pkg:
  - DATA_W = 16.
  - Complex-sample packing macros, shared with fft_stage wrappers.
  - bitrev function (LOGN-parameterized).
- One natural sub-module: fft_round_shift (combinational rounding shifter, parameter SCALE_SHIFT), instantiated once each for the real and imag paths.
- FSM, counter and buffer stay in the top module.

Test Plan:
- BITREV = 0, S = 0, frame r = {32767, 16384, 0, -16384, -32767, -16384, 0, 16384}, i = {0, 16384, 32767, 16384, 0, -16384, -32767, -16384}, out_ready = 1 -> 8 consecutive beats starting the cycle after acceptance, matching in order; out_last on beat 7; in_ready returns high.
- BITREV = 1, same frame -> out_r sequence 32767, -32767, 0, 0, 16384, -16384, -16384, 16384 (buffer order 0,4,2,6,1,5,3,7); out_idx 0..7.
- Backpressure: deassert out_ready on beats 2 and 5 for 3 cycles each -> outputs held stable, no skipped or duplicated samples, 8 beats total, in_ready = 0 throughout.
- Back-to-back: hold in_valid with a second frame (all r = 100, i = -100) while streaming -> second frame loaded on the edge beat 7 is accepted; beat 0 of frame 2 follows beat 7 of frame 1 with no idle cycle.
- SCALE_SHIFT = 1: inputs 32767, -32767, -16384, 1, -1 -> outputs 16384, -16383, -8192, 1, 0.
- Assert rst_n low during beat 3 -> out_valid = 0 immediately (async), in_ready = 1 after release; next frame streams from k = 0.
